// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath: operand/PC selects, ALUOp,
// funct codes and the internal ALU-function enumeration with its decoder.
package mc_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_fn_e;

  function automatic alu_fn_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_fn_e fn;
    fn = ALU_ADD;
    case (alu_op)
      ALUOP_ADD, ALUOP_ADD_ALT: fn = ALU_ADD;
      ALUOP_SUB:                fn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: fn = ALU_ADD;
          FUNCT_SUB: fn = ALU_SUB;
          FUNCT_AND: fn = ALU_AND;
          FUNCT_OR:  fn = ALU_OR;
          FUNCT_SLT: fn = ALU_SLT;
          default:   fn = ALU_ADD;
        endcase
      end
      default: fn = ALU_ADD;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Control and memory bus between the control FSM / memory (master side)
// and the multicycle datapath (slave side).
interface mc_datapath_if;
  import mc_pkg::*;

  logic            PCWriteCond;
  logic            PCWrite;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            MemtoReg;
  logic            IRWrite;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;

  logic [5:0]      opcode;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] pc_dbg;

  modport master (
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, mem_rdata,
    input  opcode, mem_addr, mem_wdata, mem_read, mem_write, pc_dbg
  );

  modport slave (
    input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, mem_rdata,
    output opcode, mem_addr, mem_wdata, mem_read, mem_write, pc_dbg
  );
endinterface

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// register 0 hardwired to zero.
module mc_regfile
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the array is cleared by the async reset because every register must
  // read 0 after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-style datapath: PC/IR/MDR/A/B/ALUOut, inline ALU and muxes,
// register file sub-module; sequenced entirely by the external control FSM.
module mc_datapath
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mc_datapath_if.slave bus
);

  logic [XLEN-1:0] pc, ir, mdr, a, b, alu_out;
  logic [XLEN-1:0] rd1, rd2;
  logic [XLEN-1:0] alu_a, alu_b, alu_result, imm_ext, pc_next, wr_data;
  logic [4:0]      wr_addr;
  logic            zero, pc_en;
  alu_fn_e         alu_fn;

  mc_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir[25:21]),
    .ra2   (ir[20:16]),
    .we    (bus.RegWrite),
    .wa    (wr_addr),
    .wd    (wr_data),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  assign wr_addr = bus.RegDst   ? ir[15:11] : ir[20:16];
  assign wr_data = bus.MemtoReg ? mdr       : alu_out;
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  assign alu_a   = bus.ALUSrcA  ? a         : pc;
  assign alu_fn  = alu_decode(bus.ALUOp, ir[5:0]);

  // NOTE: every signal assigned here gets a default first so no path through
  // the case statements can leave it unassigned and infer a latch.
  always_comb begin
    alu_b      = b;
    alu_result = '0;
    pc_next    = pc;

    case (bus.ALUSrcB)
      SRCB_B:      alu_b = b;
      SRCB_FOUR:   alu_b = 32'd4;
      SRCB_IMM:    alu_b = imm_ext;
      SRCB_IMM_SH: alu_b = {imm_ext[29:0], 2'b00};
      default:     alu_b = b;
    endcase

    case (alu_fn)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = alu_a + alu_b;
    endcase

    case (bus.PCSource)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PCSRC_HOLD:   pc_next = pc;
      default:      pc_next = pc;
    endcase
  end

  assign zero  = (alu_result == '0);
  assign pc_en = bus.PCWrite | (bus.PCWriteCond & zero);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (bus.IRWrite) ir <= bus.mem_rdata;
      if (pc_en)       pc <= pc_next;
      mdr     <= bus.mem_rdata;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
    end
  end

  assign bus.opcode    = ir[31:26];
  assign bus.mem_addr  = bus.IorD ? alu_out : pc;
  assign bus.mem_wdata = b;
  assign bus.mem_read  = bus.MemRead;
  assign bus.mem_write = bus.MemWrite;
  assign bus.pc_dbg    = pc;

endmodule
